seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIG_CYC, default 50000: clock cycles per digit slot, dead time included; legal range 2..65535.
REQ-002 Parameter DEAD_CYC, default 500: all-anodes-off cycles at the start of each slot; legal range 1..DIG_CYC-1.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  write strobe to the shadow register selected by wr_addr.
REQ-006 wr_addr  input  2  digit index 0..3; 0 is the rightmost digit.
REQ-007 wr_data  input  4  hex nibble for the addressed digit.
REQ-008 wr_dp  input  1  decimal point on (1) for the addressed digit.
REQ-009 wr_blank  input  1  blank (1) the addressed digit.
REQ-010 commit  input  1  single-cycle request to copy shadow to active at the next frame boundary.
REQ-011 seg  output  8  active-low segments, bit0=a .. bit6=g, bit7=dp.
REQ-012 an  output  4  active-low digit anodes, an[i] drives digit i.
REQ-013 busy  output  1  high while a commit is pending.
REQ-014 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 The block SHALL keep 4 shadow and 4 active entries of {nibble, dp, blank}; writes SHALL land only in shadow, on the edge where wr_en=1, and SHALL always be accepted (no back-pressure).
REQ-016 The FSM SHALL have two states. DEAD lasts DEAD_CYC cycles. DRIVE lasts DIG_CYC-DEAD_CYC cycles. Transitions: DEAD->DRIVE and DRIVE->DEAD; the digit index increments on DRIVE exit and wraps from 3 to 0.
REQ-017 The cycle counter SHALL be wide enough for DIG_CYC-1 and SHALL clear on every state change.
REQ-018 seg and an SHALL be registered, each reflecting the FSM state and index of the previous cycle (1-cycle latency).
REQ-019 In DEAD: an=4'hF and seg=8'hFF.
REQ-020 In DRIVE with digit i: an=~(4'b0001<<i). seg = 8'hFF if active blank[i]; otherwise decode(nibble), with bit7 cleared if dp[i].
REQ-021 decode (bit7=1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-022 Frame boundary: the last DRIVE cycle of digit 3.
  - frame_tick SHALL be high in the cycle after the boundary.
  - If a commit is pending, all 4 active entries SHALL take the shadow values (as before that cycle's write) and busy SHALL clear.
REQ-023 commit=1 SHALL set pending (busy=1 next cycle), except that commit exactly in the boundary cycle SHALL be held for the following frame.
REQ-024 Repeated commits while pending SHALL merge into one copy.
REQ-025 At most one anode SHALL be low in any cycle, and an SHALL be 4'hF for ≥DEAD_CYC cycles between two different low anodes.

Reset
REQ-026 While rst=1 at a clock edge:
  - state=DEAD, index=0, counter=0;
  - seg=8'hFF, an=4'hF, busy=0, frame_tick=0;
  - all shadow and active entries = {0,0,blank=1}; pending=0.
REQ-027 rst mid-frame or mid-commit SHALL discard pending and shadow contents with no partial copy.
REQ-028 The first DEAD state SHALL begin on the first edge with rst=0.

Verification (DIG_CYC=8, DEAD_CYC=2)
REQ-029 Reset, then idle 40 cycles -> an stays 4'hF for DEAD slots, and seg=FF throughout (all digits blank); frame_tick every 32 cycles.
REQ-030 Write digits 0..3 = 1,2,3,4 (blank=0) and commit -> busy=1 until the boundary. The next frame shows digit0 seg=F9, digit1 seg=A4, digit2 seg=B0, digit3 seg=99, each for 6 cycles after 2 dark cycles.
REQ-031 Write digit2 = A with dp=1, without commit -> display unchanged for 3 frames. Then commit -> digit2 seg=08 from the next frame.
REQ-032 Commit in the boundary cycle -> no copy at that boundary; busy stays 1 and the copy occurs one frame later.
REQ-033 Assert rst during DRIVE of digit1 with a commit pending -> next cycle an=F, seg=FF, busy=0; display returns to blank after resume.
REQ-034 All 16 nibbles written via digit0 and committed -> each seg matches the REQ-021 table; an one-hot-low check holds every cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed driver for a 4-digit common-anode 7-segment display
//           with double-buffered digit contents and frame-aligned commit.
// Latency : seg/an are registered, showing the scan state of the previous cycle;
//           a commit takes effect at the next frame boundary (busy shows pending).
// Backpr. : none; shadow writes and commit requests are always accepted.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   wr_en      - write strobe into the shadow entry selected by wr_addr
//   wr_addr    - digit index 0..3 (0 = rightmost)
//   wr_data    - hex nibble for the addressed digit
//   wr_dp      - decimal point on (1) for the addressed digit
//   wr_blank   - blank (1) the addressed digit
//   commit     - one-cycle request to copy shadow -> active at the next frame boundary
//   seg        - active-low segments, bit0=a .. bit6=g, bit7=dp
//   an         - active-low anodes, an[i] drives digit i
//   busy       - high while a commit is pending
//   frame_tick - one-cycle pulse in the cycle after each frame boundary

module seg7_scan_ctrl #(
  parameter int unsigned DIG_CYC  = 50000,
  parameter int unsigned DEAD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic       commit,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       frame_tick
);

  // Counter only has to reach DIG_CYC-1, the longest possible phase length.
  localparam int unsigned CNT_W = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIG_CYC - DEAD_CYC - 1);

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RST = '{nib: 4'h0, dp: 1'b0, blank: 1'b1};

  // Hex to active-low segment pattern; dp bit (bit7) left off here.
  function automatic logic [7:0] decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  digit_t           shadow_q [4];
  digit_t           shadow_d [4];
  digit_t           active_q [4];
  digit_t           active_d [4];
  logic             pending_q, pending_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;

  logic             boundary;
  digit_t           cur;
  logic [7:0]       dec;

  // Last DRIVE cycle of digit 3 closes the frame.
  assign boundary = (state_q == ST_DRIVE) && (idx_q == 2'd3) && (cnt_q == DRIVE_LAST);

  // ---------------------------------------------------------------------------
  // Scan sequencing: DEAD (all anodes off) then DRIVE, once per digit slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_DEAD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow/active buffers and commit handshake.
  // The copy reads shadow_q, so a write landing in the boundary cycle itself
  // is not part of that copy; it waits for the next commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
    end
    pending_d = pending_q;

    if (wr_en) begin
      shadow_d[wr_addr] = '{nib: wr_data, dp: wr_dp, blank: wr_blank};
    end

    if (boundary) begin
      if (pending_q) begin
        for (int i = 0; i < 4; i++) begin
          active_d[i] = shadow_q[i];
        end
      end
      // A commit arriving exactly on the boundary belongs to the next frame.
      pending_d = commit;
    end else if (commit) begin
      // Further commits while pending collapse into the one copy.
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pattern for the current scan state, registered below.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur    = active_q[idx_q];
    dec    = decode(cur.nib);
    seg_d  = 8'hFF;
    an_d   = 4'hF;
    tick_d = boundary;
    if (state_q == ST_DRIVE) begin
      an_d = ~(4'b0001 << idx_q);
      if (!cur.blank) begin
        seg_d    = dec;
        seg_d[7] = ~cur.dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_DEAD;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pending_q <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
      tick_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= DIGIT_RST;
        active_q[i] <= DIGIT_RST;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign busy       = pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose : directed self-checking bench for seg7_scan_ctrl with DIG_CYC=8, DEAD_CYC=2.
// Timing  : a frame is 32 cycles; sampling happens 1 time unit after each rising edge.
// Flow    : inputs are driven in the same post-edge slot, one scenario task at a time.

module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic       commit;
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Expected active-low patterns for nibbles 0..F (dp off).
  logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  // Expected low-anode pattern per digit.
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIG_CYC (8),
    .DEAD_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .commit    (commit),
    .seg       (seg),
    .an        (an),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic dp, input logic bl);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_dp    = dp;
    wr_blank = bl;
    step();
    wr_en    = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // Advance until frame_tick is seen; n is the number of edges taken (capped).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 100);
  endtask

  // Starting in a frame_tick cycle, walk one full frame checking every cycle.
  task automatic test_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] es [4];
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_tick;
    int k, p;
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    for (int off = 1; off <= 32; off++) begin
      step();
      k        = (off - 1) / 8;
      p        = (off - 1) % 8;
      exp_an   = (p < 2) ? 4'hF : an_tab[k];
      exp_seg  = (p < 2) ? 8'hFF : es[k];
      exp_tick = (off == 32);
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL %s an off=%0d got=%h exp=%h", nm, off, an, exp_an);
      end
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL %s seg off=%0d got=%h exp=%h", nm, off, seg, exp_seg);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL %s onehot off=%0d got=%h exp=at most one low", nm, off, an);
      end
      checks++;
      if (frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL %s tick off=%0d got=%b exp=%b", nm, off, frame_tick, exp_tick);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=f", an); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
  endtask

  task automatic test_idle();
    int n;
    rst = 1'b0;
    wait_tick(n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL idle_first_tick got=%0d exp=32", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    test_frame("idle_a", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    test_frame("idle_b", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
  endtask

  task automatic test_commit();
    int n;
    wr(2'd0, 4'h1, 1'b0, 1'b0);
    wr(2'd1, 4'h2, 1'b0, 1'b0);
    wr(2'd2, 4'h3, 1'b0, 1'b0);
    wr(2'd3, 4'h4, 1'b0, 1'b0);
    pulse_commit();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy_set got=%b exp=1", busy); end
    wait_tick(n);
    checks++;
    if (n != 27) begin errors++; $display("FAIL commit_tick_wait got=%0d exp=27", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL commit_busy_clr got=%b exp=0", busy); end
    test_frame("commit_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
  endtask

  task automatic test_no_commit();
    int n;
    wr(2'd2, 4'hA, 1'b1, 1'b0);
    wait_tick(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL nocommit_tick_wait got=%0d exp=31", n); end
    for (int f = 0; f < 3; f++) test_frame("nocommit_hold", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    pulse_commit();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nocommit_busy got=%b exp=1", busy); end
    wait_tick(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL nocommit_tick2 got=%0d exp=31", n); end
    test_frame("dp_digit2", 8'hF9, 8'hA4, 8'h08, 8'h99);
  endtask

  task automatic test_boundary_commit();
    wr(2'd0, 4'h5, 1'b0, 1'b0);
    repeat (30) step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL bnd_align got=%b exp=1", frame_tick); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bnd_busy_held got=%b exp=1", busy); end
    test_frame("bnd_no_copy", 8'hF9, 8'hA4, 8'h08, 8'h99);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bnd_busy_clr got=%b exp=0", busy); end
    test_frame("bnd_copied", 8'h92, 8'hA4, 8'h08, 8'h99);
  endtask

  task automatic test_reset_mid();
    int n;
    wr(2'd1, 4'h7, 1'b0, 1'b0);
    pulse_commit();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy); end
    repeat (10) step();
    checks++;
    if (an !== 4'hD) begin errors++; $display("FAIL rstmid_digit1 got=%h exp=d", an); end
    rst = 1'b1;
    step();
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL rstmid_an got=%h exp=f", an); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL rstmid_seg got=%h exp=ff", seg); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    rst = 1'b0;
    wait_tick(n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL rstmid_tick got=%0d exp=32", n); end
    test_frame("rstmid_blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    // Committing now copies the cleared shadow, so the display stays blank.
    pulse_commit();
    wait_tick(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL rstmid_tick2 got=%0d exp=31", n); end
    test_frame("rstmid_shadow_clr", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
  endtask

  task automatic test_all_nibbles();
    int n;
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 4'(i), 1'b0, 1'b0);
      pulse_commit();
      wait_tick(n);
      checks++;
      if (n != 30) begin errors++; $display("FAIL nib_tick nib=%0d got=%0d exp=30", i, n); end
      test_frame("nibble", dec_tab[i], 8'hFF, 8'hFF, 8'hFF);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 4'h0;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;
    commit   = 1'b0;
    #1;
    test_reset();
    test_idle();
    test_commit();
    test_no_commit();
    test_boundary_commit();
    test_reset_mid();
    test_all_nibbles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1);
  end

endmodule
